hazard_stall_sequencer: RTL
===========================

HAZARD_STALL_SEQUENCER -- requirements
Module: hazard_stall_sequencer

Interface
REQ-001 Parameter MMIO_TIMEOUT_CYCLES, default 255, meaning max MMIO_WAIT cycles before abandon; range 1..255.
REQ-002 i_clk  input  1  sole clock, rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_flush  input  1  pipeline flush request.
REQ-005 i_id_valid, i_id_uses_rs1, i_id_uses_rs2  input  1 each  ID instruction valid / reads rs1 / reads rs2.
REQ-006 i_id_rs1, i_id_rs2  input  5 each  ID source registers (early PD copies).
REQ-007 i_ex_valid, i_ex_is_load  input  1 each  EX valid; EX is load or LR.
REQ-008 i_ex_dest_reg  input  5  EX destination register.
REQ-009 i_ex_cache_hit  input  1  L0 cache hit for the EX load.
REQ-010 i_ma_is_amo  input  1  AMO present in MA.
REQ-011 i_ma_mmio_load  input  1  load/LR to MMIO range present in MA.
REQ-012 i_mmio_rvalid  input  1  MMIO read data valid this cycle.
REQ-013 o_stall  output  1  freeze PD/ID/EX/MA.
REQ-014 o_load_use_hazard_detected  output  1  raw hazard flag.
REQ-015 o_stall_for_load_use_hazard  output  1  stall cause is load-use (forwarding unit captures load data).
REQ-016 o_amo_read_phase, o_amo_write_enable  output  1 each  AMO phase strobes.
REQ-017 o_mmio_timeout  output  1  one-cycle pulse on MMIO abandon.
REQ-018 o_state  output  3  FSM state encoding: IDLE=0, LOAD_USE=1, MMIO_WAIT=2, AMO_READ=3, AMO_WRITE=4.

Function
REQ-019 hazard = i_ex_valid & i_id_valid & i_ex_is_load & (i_ex_dest_reg!=0) & ((i_id_uses_rs1 & rs1==dest) | (i_id_uses_rs2 & rs2==dest)), combinational.
REQ-020 o_load_use_hazard_detected SHALL equal hazard in every state, masked to 0 in LOAD_USE.
REQ-021 IDLE priority: i_ma_is_amo > (i_ma_mmio_load & ~i_mmio_rvalid) > hazard.
REQ-022 IDLE + AMO: o_stall=1 same cycle; next AMO_READ.
REQ-023 AMO_READ: o_stall=1, o_amo_read_phase=1; next AMO_WRITE unconditionally.
REQ-024 AMO_WRITE: o_stall=0, o_amo_write_enable=1; next IDLE; AMO sequence total 3 cycles, 2 stalled.
REQ-025 IDLE + MMIO pending: o_stall=1 same cycle; next MMIO_WAIT; counter cleared to 0.
REQ-026 MMIO_WAIT: o_stall = ~i_mmio_rvalid; counter +1 per cycle; rvalid -> IDLE next.
REQ-027 MMIO_WAIT with counter==MMIO_TIMEOUT_CYCLES-1 and no rvalid: o_mmio_timeout=1, o_stall=0 that cycle, next IDLE.
REQ-028 IDLE + hazard (no higher priority): o_stall=1 and o_stall_for_load_use_hazard=1 same cycle; next LOAD_USE.
REQ-029 LOAD_USE: exactly one cycle, o_stall=0, hazard masked; next IDLE.
REQ-030 Hazard during MMIO_WAIT/AMO states: flag reported, no state change, o_stall_for_load_use_hazard=0; re-evaluated on IDLE return.
REQ-031 i_flush in LOAD_USE or MMIO_WAIT: next IDLE, stall deasserted same cycle; i_flush in IDLE suppresses entry; AMO_READ/AMO_WRITE ignore i_flush.
REQ-032 Counter 8 bits, saturating, never wraps.
REQ-033 All outputs except o_state combinational from registered state plus inputs; no output depends on itself.

Reset
REQ-034 i_rst_n low: state=IDLE, counter=0 asynchronously; outputs then follow REQ-019..033 (all 0 with idle inputs).
REQ-035 Reset mid-AMO or mid-MMIO_WAIT SHALL abort immediately with no o_amo_write_enable or o_mmio_timeout pulse.

Configuration
REQ-036 Macro FROST_HAZARD_CACHE_HIT_BYPASS_EN defined: hazard additionally gated by ~i_ex_cache_hit (L0 hit forwards with zero stall).
REQ-037 Macro undefined: i_ex_cache_hit ignored; every matching load stalls one cycle.

Verification
REQ-038 lw x5 in EX, ID add x6,x5,x1, no hit -> o_stall=1 and o_stall_for_load_use_hazard=1 one cycle, o_state=1 next, then 0.
REQ-039 Same with i_ex_cache_hit=1 -> macro defined: no stall; undefined: 1-cycle stall.
REQ-040 i_ex_dest_reg=0, rs1=0 -> no hazard, no stall.
REQ-041 i_ma_is_amo=1 in IDLE -> o_stall 1,1,0; o_amo_read_phase at cycle 2; o_amo_write_enable at cycle 3; i_flush mid-sequence ignored.
REQ-042 MMIO load, rvalid after 4 cycles -> stall 4 cycles then release; MMIO_TIMEOUT_CYCLES=8, no rvalid -> o_mmio_timeout pulse at counter 7, IDLE next.
REQ-043 i_rst_n low during AMO_READ -> o_state=0 immediately, no write-enable pulse after release.

Source files
------------

// File: rtl/hazard_stall_sequencer.sv
// Hazard stall sequencer: detects load-use hazards and sequences the pipeline
// stalls needed for load-use bubbles, MMIO read waits (with timeout) and the
// two-phase AMO read/write.
// Optional build macro FROST_HAZARD_CACHE_HIT_BYPASS_EN: an L0 cache hit on the
// EX load forwards with zero stall, so it suppresses the load-use hazard.
module hazard_stall_sequencer #(
    parameter int unsigned MMIO_TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_id_valid,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_dest_reg,
    input  logic       i_ex_cache_hit,
    input  logic       i_ma_is_amo,
    input  logic       i_ma_mmio_load,
    input  logic       i_mmio_rvalid,
    output logic       o_stall,
    output logic       o_load_use_hazard_detected,
    output logic       o_stall_for_load_use_hazard,
    output logic       o_amo_read_phase,
    output logic       o_amo_write_enable,
    output logic       o_mmio_timeout,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_USE  = 3'd1,
        MMIO_WAIT = 3'd2,
        AMO_READ  = 3'd3,
        AMO_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MMIO_TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_count;
    logic       hazard;
    logic       raw_match;
    logic       mmio_pending;
    logic       mmio_timeout_hit;

    // Raw load-use match between the EX load destination and the ID sources.
    always_comb begin
        raw_match = i_ex_valid & i_id_valid & i_ex_is_load & (i_ex_dest_reg != 5'd0) &
                    ((i_id_uses_rs1 & (i_id_rs1 == i_ex_dest_reg)) |
                     (i_id_uses_rs2 & (i_id_rs2 == i_ex_dest_reg)));
    end

`ifdef FROST_HAZARD_CACHE_HIT_BYPASS_EN
    // An L0 hit forwards load data directly, so no bubble is required.
    always_comb hazard = raw_match & ~i_ex_cache_hit;
`else
    logic cache_hit_unused;
    assign cache_hit_unused = i_ex_cache_hit;
    // Every matching load costs one bubble.
    always_comb hazard = raw_match;
`endif

    // Shared decode terms for next-state and output logic.
    always_comb begin
        mmio_pending     = i_ma_mmio_load & ~i_mmio_rvalid;
        mmio_timeout_hit = ~i_mmio_rvalid & (wait_count == TIMEOUT_LAST);
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MMIO wait counter: cleared on entry, saturating count while waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_count <= '0;
        end else if (state == IDLE && state_next == MMIO_WAIT) begin
            wait_count <= '0;
        end else if (state == MMIO_WAIT && wait_count != 8'hFF) begin
            wait_count <= wait_count + 8'd1;
        end
    end

    // Next-state selection; IDLE priority is AMO, then MMIO, then load-use.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!i_flush) begin
                    if (i_ma_is_amo) begin
                        state_next = AMO_READ;
                    end else if (mmio_pending) begin
                        state_next = MMIO_WAIT;
                    end else if (hazard) begin
                        state_next = LOAD_USE;
                    end
                end
            end
            LOAD_USE:  state_next = IDLE;
            MMIO_WAIT: begin
                if (i_flush || i_mmio_rvalid || mmio_timeout_hit) begin
                    state_next = IDLE;
                end
            end
            AMO_READ:  state_next = AMO_WRITE;
            AMO_WRITE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output decode from registered state and current inputs.
    always_comb begin
        o_stall                     = 1'b0;
        o_stall_for_load_use_hazard = 1'b0;
        o_amo_read_phase            = 1'b0;
        o_amo_write_enable          = 1'b0;
        o_mmio_timeout              = 1'b0;
        o_load_use_hazard_detected  = hazard & (state != LOAD_USE);
        o_state                     = state;
        unique case (state)
            IDLE: begin
                if (!i_flush) begin
                    if (i_ma_is_amo || mmio_pending) begin
                        o_stall = 1'b1;
                    end else if (hazard) begin
                        o_stall                     = 1'b1;
                        o_stall_for_load_use_hazard = 1'b1;
                    end
                end
            end
            LOAD_USE: ;
            MMIO_WAIT: begin
                if (!i_flush && !i_mmio_rvalid) begin
                    if (mmio_timeout_hit) begin
                        o_mmio_timeout = 1'b1;
                    end else begin
                        o_stall = 1'b1;
                    end
                end
            end
            AMO_READ: begin
                o_stall          = 1'b1;
                o_amo_read_phase = 1'b1;
            end
            AMO_WRITE: o_amo_write_enable = 1'b1;
            default: ;
        endcase
    end

endmodule
